// File: rtl/data_capture_buf_if.sv
// data_capture_buf_if: capture strobe and valid/ready read handshake of the capture buffer
interface data_capture_buf_if #(parameter int WIDTH = 4);
    logic             cap_en;
    logic [WIDTH-1:0] cap_d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    modport master (output cap_en, cap_d, out_ready, input out_valid, out_data);
    modport slave  (input cap_en, cap_d, out_ready, output out_valid, out_data);
endinterface

// File: rtl/data_capture_buf.sv
// data_capture_buf: circular capture buffer for launched words, first-word-fall-through read side
module data_capture_buf #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    data_capture_buf_if.slave        bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             push, pop, drop;
    assign empty         = count == '0;
    assign full          = count == CW'(DEPTH);
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem[rp];
    assign pop           = bus.out_valid && bus.out_ready;
    // a pop frees the head slot at the same edge, so a full buffer still accepts
    assign push          = bus.cap_en && (!full || pop);
    assign drop          = bus.cap_en && full && !pop;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wp] <= bus.cap_d;
                wp      <= wp + AW'(1);
            end
            if (pop) rp <= rp + AW'(1);
            count    <= (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
            overflow <= drop ? 1'b1 : clr_ovf ? 1'b0 : overflow;
        end
    end
endmodule
